// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder.
// I/O map, STATUS layout and default sizes.
package dmem_responder_pkg;

  localparam int DMEM_DATA_WIDTH = 8;
  localparam int DMEM_ADDR_WIDTH = 8;
  localparam int DMEM_FIFO_DEPTH = 4;

  localparam logic [7:0] IO_BASE = 8'hFC;

  localparam logic [1:0] OFS_OUT    = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_TICK   = 2'd2;
  localparam logic [1:0] OFS_CTRL   = 2'd3;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_CNT   = 2;
  localparam int ST_OVF   = 7;

  function automatic logic [7:0] status_byte(
    input logic       full,
    input logic       empty,
    input logic [3:0] cnt,
    input logic       ovf
  );
    logic [7:0] s;
    s              = '0;
    s[ST_FULL]     = full;
    s[ST_EMPTY]    = empty;
    s[ST_CNT +: 3] = (cnt > 4'd7) ? 3'd7 : cnt[2:0];
    s[ST_OVF]      = ovf;
    return s;
  endfunction

endpackage

// File: rtl/dmem_responder_fifo.sv
// Circular output FIFO with push/pop and occupancy flags.
// Head reads as zero when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);
  assign rdata   = empty ? '0 : mem_q[rd_ptr];

  // storage write, no reset on contents
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr] <= wdata;
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory endpoint: RAM below the I/O window,
// output FIFO, status and tick counter above it.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int FIFO_DEPTH = DMEM_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_wenable,
  input  logic [DATA_WIDTH-1:0] mem_wvalue,
  output logic [DATA_WIDTH-1:0] mem_rvalue,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);

  localparam int RAM_WORDS = (1 << ADDR_WIDTH) - 4;
  localparam int CW        = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] ram [RAM_WORDS];

  logic                  is_io;
  logic                  sel_ram;
  logic                  sel_out;
  logic                  sel_st;
  logic                  sel_tk;
  logic                  sel_ctl;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] head;
  logic                  ovf;
  logic [7:0]            tick;
  logic                  tick_en;

  assign is_io   = &mem_addr[ADDR_WIDTH-1:2];
  assign sel_ram = !is_io;
  assign sel_out = is_io && (mem_addr[1:0] == OFS_OUT);
  assign sel_st  = is_io && (mem_addr[1:0] == OFS_STATUS);
  assign sel_tk  = is_io && (mem_addr[1:0] == OFS_TICK);
  assign sel_ctl = is_io && (mem_addr[1:0] == OFS_CTRL);

  assign pop       = out_valid && out_ready;
  assign push      = mem_wenable && sel_out;
  assign out_valid = !empty;
  assign out_data  = head;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (mem_wvalue),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // RAM write port, contents survive reset
  always_ff @(posedge clk) begin
    if (mem_wenable && sel_ram) ram[mem_addr] <= mem_wvalue;
  end

  // sticky overflow: set on a dropped push, cleared by STATUS write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     ovf <= 1'b0;
    else if (mem_wenable && sel_st) ovf <= 1'b0;
    else if (push && full && !pop)  ovf <= 1'b1;
  end

  // tick counter; a load beats the increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick    <= 8'h00;
      tick_en <= 1'b0;
    end else begin
      if (mem_wenable && sel_tk) tick <= mem_wvalue[7:0];
      else if (tick_en)          tick <= tick + 8'h01;
      if (mem_wenable && sel_ctl) tick_en <= mem_wvalue[0];
    end
  end

  // combinational read mux
  always_comb begin
    mem_rvalue = '0;
    unique case (1'b1)
      sel_ram: mem_rvalue      = ram[mem_addr];
      sel_out: mem_rvalue      = head;
      sel_st:  mem_rvalue[7:0] = status_byte(full, empty,
                                             4'(count), ovf);
      sel_tk:  mem_rvalue[7:0] = tick;
      sel_ctl: mem_rvalue[0]   = tick_en;
      default: mem_rvalue      = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder.
// RAM, FIFO, status, tick and reset checks.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] mem_addr;
  logic       mem_wenable;
  logic [7:0] mem_wvalue;
  logic [7:0] mem_rvalue;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  int n_total = 0;
  int n_bad   = 0;

  dmem_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_addr    (mem_addr),
    .mem_wenable (mem_wenable),
    .mem_wvalue  (mem_wvalue),
    .mem_rvalue  (mem_rvalue),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a,
                    input logic [7:0] d);
    @(negedge clk);
    mem_addr    = a;
    mem_wenable = 1'b1;
    mem_wvalue  = d;
    @(posedge clk);
    #1;
    mem_wenable = 1'b0;
  endtask

  task automatic rd(input string tag,
                    input logic [7:0] a,
                    input logic [7:0] exp);
    mem_addr = a;
    #1;
    chk(tag, mem_rvalue, exp);
  endtask

  logic [7:0] exp_q [$];

  initial begin
    rst_n       = 1'b0;
    mem_addr    = 8'h00;
    mem_wenable = 1'b0;
    mem_wvalue  = 8'h00;
    out_ready   = 1'b0;
    #12;
    chk("rst_valid", {7'b0, out_valid}, 8'h00);
    chk("rst_data", out_data, 8'h00);
    rd("rst_status", 8'hFD, 8'h02);
    rd("rst_tick", 8'hFE, 8'h00);
    rd("rst_ctrl", 8'hFF, 8'h00);
    rd("rst_outreg", 8'hFC, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    wr(8'h10, 8'h5A);
    rd("ram10", 8'h10, 8'h5A);
    wr(8'h11, 8'hA5);
    rd("ram11", 8'h11, 8'hA5);
    rd("ram10_keep", 8'h10, 8'h5A);

    for (int i = 0; i < 4; i++) wr(8'hFC, 8'h41 + 8'(i));
    rd("st_full", 8'hFD, 8'h11);
    chk("head41", out_data, 8'h41);
    chk("valid_full", {7'b0, out_valid}, 8'h01);
    rd("outreg41", 8'hFC, 8'h41);
    wr(8'hFC, 8'h45);
    rd("st_ovf", 8'hFD, 8'h91);
    chk("head_kept", out_data, 8'h41);

    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_v", {7'b0, out_valid}, 8'h01);
      chk("drain_d", out_data, 8'h41 + 8'(i));
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("drained_v", {7'b0, out_valid}, 8'h00);
    chk("drained_d", out_data, 8'h00);
    rd("st_drained", 8'hFD, 8'h82);
    rd("outreg_empty", 8'hFC, 8'h00);

    for (int i = 0; i < 4; i++) wr(8'hFC, 8'h41 + 8'(i));
    rd("st_full_ovf", 8'hFD, 8'h91);
    wr(8'hFD, 8'h00);
    rd("st_ovf_clr", 8'hFD, 8'h11);

    @(negedge clk);
    mem_addr    = 8'hFC;
    mem_wenable = 1'b1;
    mem_wvalue  = 8'h46;
    out_ready   = 1'b1;
    #1;
    chk("pp_head", out_data, 8'h41);
    @(posedge clk);
    #1;
    mem_wenable = 1'b0;
    out_ready   = 1'b0;
    rd("st_pushpop", 8'hFD, 8'h11);
    chk("pp_head2", out_data, 8'h42);

    exp_q = '{8'h42, 8'h43, 8'h44, 8'h46};
    @(negedge clk);
    out_ready = 1'b1;
    foreach (exp_q[i]) begin
      chk("pp_drain", out_data, exp_q[i]);
      @(negedge clk);
    end
    out_ready = 1'b0;
    rd("st_pp_empty", 8'hFD, 8'h02);

    wr(8'hFF, 8'h01);
    rd("ctrl_on", 8'hFF, 8'h01);
    rd("tick0", 8'hFE, 8'h00);
    @(posedge clk); #1;
    rd("tick1", 8'hFE, 8'h01);
    @(posedge clk); #1;
    rd("tick2", 8'hFE, 8'h02);
    wr(8'hFE, 8'hFE);
    rd("tickFE", 8'hFE, 8'hFE);
    @(posedge clk); #1;
    rd("tickFF", 8'hFE, 8'hFF);
    @(posedge clk); #1;
    rd("tick_wrap", 8'hFE, 8'h00);
    wr(8'hFF, 8'h00);
    rd("tick_stop", 8'hFE, 8'h01);
    @(posedge clk); #1;
    rd("tick_hold", 8'hFE, 8'h01);
    rd("ctrl_off", 8'hFF, 8'h00);

    wr(8'hFC, 8'h11);
    wr(8'hFC, 8'h22);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("mid_head", out_data, 8'h22);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", {7'b0, out_valid}, 8'h00);
    chk("mr_data", out_data, 8'h00);
    rd("mr_status", 8'hFD, 8'h02);
    rd("mr_tick", 8'hFE, 8'h00);
    rd("mr_ram", 8'h10, 8'h5A);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    rd("post_status", 8'hFD, 8'h02);
    rd("post_ram11", 8'h11, 8'hA5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
